store_checker: RTL
==================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter DATA_W, default 32: store data width.
REQ-002 Parameter ADDR_W, default 32: store address width.
REQ-003 Parameter DEPTH, default 4: number of expected-store entries, minimum 1.
REQ-004 Parameter TIMEOUT_CYC, default 1024: RUN-state cycle budget, minimum 2.
REQ-005 Parameter IGNORE_EN, default 1: enables the tolerated-address filter.
REQ-006 Parameter IGNORE_ADDR, default 80: tolerated store address, skipped without a compare.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 memwrite  in  1  observed store strobe.
REQ-010 addr  in  ADDR_W  observed store address.
REQ-011 writedata  in  DATA_W  observed store data.
REQ-012 load_valid  in  1  writes one expected entry while IDLE.
REQ-013 load_addr / load_data  in  ADDR_W / DATA_W  expected entry contents.
REQ-014 start  in  1  arms checking.
REQ-015 clear  in  1  returns from PASS/FAIL to IDLE and empties the table.
REQ-016 busy / pass / fail  out  1 each  RUN, PASS and FAIL state indicators.
REQ-017 fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 empty table.
REQ-018 match_count  out  $clog2(DEPTH+1)  number of matched stores.
REQ-019 bad_addr / bad_data  out  ADDR_W / DATA_W  first mismatching store captured.
REQ-020 load_ovf  out  1  sticky flag: a load was attempted with the table full.

Function
REQ-021 The FSM SHALL have the states IDLE, RUN, PASS and FAIL; PASS and FAIL are terminal until clear or reset.
REQ-022 In IDLE, load_valid SHALL write entry[wr_ptr] and increment wr_ptr; when wr_ptr==DEPTH the load SHALL be dropped and load_ovf set.
REQ-023 In IDLE, start with wr_ptr>0 SHALL enter RUN with rd_ptr=0, timer=0 and match_count=0.
REQ-024 In IDLE, start with wr_ptr==0 SHALL enter FAIL with fail_code=3.
REQ-025 In IDLE, load_valid and start in the same cycle SHALL perform the load first, and start SHALL count the new entry.
REQ-026 In RUN, the timer SHALL increment every cycle.
REQ-027 In RUN, memwrite with IGNORE_EN=1 and addr==IGNORE_ADDR SHALL be ignored.
REQ-028 In RUN, any other memwrite SHALL be compared against entry[rd_ptr] on address and data, both of which must be equal.
REQ-029 On a match, rd_ptr and match_count SHALL increment; a match on the last loaded entry SHALL enter PASS.
REQ-030 On a mismatch, the block SHALL enter FAIL with fail_code=1 and latch addr/writedata into bad_addr/bad_data.
REQ-031 If the timer reaches TIMEOUT_CYC-1 without completion, the block SHALL enter FAIL with fail_code=2.
REQ-032 A completing match in the timeout cycle SHALL take priority and enter PASS.
REQ-033 load_valid and start outside IDLE SHALL be ignored, and load_ovf SHALL NOT be set.
REQ-034 clear in PASS/FAIL SHALL return to IDLE and zero wr_ptr, rd_ptr, match_count, fail_code, bad_* and load_ovf; clear in IDLE/RUN SHALL be ignored.
REQ-035 All outputs SHALL be registered, with state visible one cycle after the sampling edge.

Reset
REQ-036 While reset is sampled high: state=IDLE; every output, pointer and timer =0; table contents don't-care.
REQ-037 Reset SHALL override start, load_valid and clear in the same cycle, and a reset mid-RUN SHALL abort without flagging PASS or FAIL.

Structure
REQ-038 Package store_checker_pkg SHALL hold the state enum, the fail_code enum and the fail-code constants.
REQ-039 The expected table SHALL be a sub-module exp_table: DEPTH x (ADDR_W+DATA_W) register file, one write port, one combinational read port.

Verification
REQ-040 Scenario 1, DEPTH=4: load (84,7), start; store (80,3) then (84,7) -> PASS, match_count=1, fail_code=0.
REQ-041 Scenario 2: load (84,7), start; store (84,6) -> FAIL, fail_code=1, bad_addr=84, bad_data=6.
REQ-042 Scenario 3, TIMEOUT_CYC=16: load one entry, start, no stores -> FAIL with fail_code=2 exactly 16 cycles after start.
REQ-043 Scenario 4, TIMEOUT_CYC=16: the last matching store lands in the timeout cycle -> PASS, fail_code=0.
REQ-044 Scenario 5, DEPTH=4: five loads -> load_ovf=1 and a 4-entry run passes; then start with an empty table after clear -> FAIL, fail_code=3.
REQ-045 Scenario 6: reset asserted mid-RUN after 2 matches -> next cycle IDLE, match_count=0, busy=0, pass=0, fail=0.

Source files
------------

// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM states and failure classification.
package store_checker_pkg;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_MISMATCH = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
    localparam logic [1:0] FAIL_EMPTY    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = FAIL_NONE,
        FC_MISMATCH = FAIL_MISMATCH,
        FC_TIMEOUT  = FAIL_TIMEOUT,
        FC_EMPTY    = FAIL_EMPTY
    } fail_code_t;

endpackage

// File: rtl/store_checker_table.sv
// Expected-store register file: one synchronous write port, one combinational read port.
module exp_table
    import store_checker_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [IDX_W-1:0]  r_idx,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];

    // Contents are not reset; only entries below the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_idx] <= {w_addr, w_data};
        end
    end

    assign {r_addr, r_data} = mem[r_idx];

endmodule

// File: rtl/store_checker.sv
// Compares an observed store stream against a preloaded list of expected stores.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit IGNORE_EN   = 1'b1,
    parameter int IGNORE_ADDR = 80
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       load_valid,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       start,
    input  logic                       clear,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH+1)-1:0] match_count,
    output logic [ADDR_W-1:0]          bad_addr,
    output logic [DATA_W-1:0]          bad_data,
    output logic                       load_ovf
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    state_t             state;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [TMR_W-1:0]   timer;
    logic [ADDR_W-1:0]  exp_addr;
    logic [DATA_W-1:0]  exp_data;
    logic               table_full;
    logic               table_we;
    logic               store_seen;
    logic               hit;
    logic               last_entry;
    logic               timed_out;

    assign table_full = (wr_ptr == CNT_W'(DEPTH));
    assign table_we   = (state == S_IDLE) && load_valid && !table_full && !reset;
    assign store_seen = memwrite && !(IGNORE_EN && (addr == ADDR_W'(IGNORE_ADDR)));
    assign hit        = (addr == exp_addr) && (writedata == exp_data);
    assign last_entry = (rd_ptr == wr_ptr - CNT_W'(1));
    assign timed_out  = (timer == TMR_W'(TIMEOUT_CYC - 1));

    exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk    (clk),
        .we     (table_we),
        .w_idx  (wr_ptr[IDX_W-1:0]),
        .w_addr (load_addr),
        .w_data (load_data),
        .r_idx  (rd_ptr[IDX_W-1:0]),
        .r_addr (exp_addr),
        .r_data (exp_data)
    );

    // A load in the same cycle as start counts toward the table being non-empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            match_count <= '0;
            fail_code   <= FC_NONE;
            bad_addr    <= '0;
            bad_data    <= '0;
            load_ovf    <= 1'b0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_valid) begin
                        if (table_full) begin
                            load_ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + CNT_W'(1);
                        end
                    end
                    if (start) begin
                        if ((wr_ptr != '0) || load_valid) begin
                            state       <= S_RUN;
                            busy        <= 1'b1;
                            rd_ptr      <= '0;
                            timer       <= '0;
                            match_count <= '0;
                        end else begin
                            state     <= S_FAIL;
                            fail      <= 1'b1;
                            fail_code <= FC_EMPTY;
                        end
                    end
                end
                S_RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (store_seen && !hit) begin
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= FC_MISMATCH;
                        bad_addr  <= addr;
                        bad_data  <= writedata;
                    end else if (store_seen) begin
                        rd_ptr      <= rd_ptr + CNT_W'(1);
                        match_count <= match_count + CNT_W'(1);
                        if (last_entry) begin
                            state <= S_PASS;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else if (timed_out) begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                            fail_code <= FC_TIMEOUT;
                        end
                    end else if (timed_out) begin
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                S_PASS, S_FAIL: begin
                    if (clear) begin
                        state       <= S_IDLE;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        timer       <= '0;
                        match_count <= '0;
                        fail_code   <= FC_NONE;
                        bad_addr    <= '0;
                        bad_data    <= '0;
                        load_ovf    <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
